// File: rtl/move_scheduler.sv
// move_scheduler: sequences one 2048 turn at a time (move, spawn, check) and
// queues edge-triggered direction commands so presses made mid-turn are kept.
// Owns the effective-move step counter and the play/dead/win status.
//
// Ports:
//   clk_i        game clock
//   rst_i        synchronous reset, active-high
//   key_i        debounced key levels {up,down,left,right}
//   mv_en_o      one-cycle strobe: board applies move mv_dir_o
//   mv_dir_o     00 up, 01 down, 10 left, 11 right (holds last popped dir)
//   moved_i      board changed by last move; valid the cycle after mv_en_o
//   spawn_en_o   one-cycle strobe: board inserts a random tile
//   chk_en_o     level: evaluate dead/win, held until chk_done_i
//   chk_done_i   check result valid this cycle
//   chk_dead_i   no legal move remains (qualified by chk_done_i)
//   chk_win_i    2048 tile present (qualified by chk_done_i)
//   status_o     0 play, 1 dead, 2 win
//   step_o       count of completed effective moves (saturating)
//   busy_o       scheduler not idle
//   fifo_full_o  command FIFO holds Depth entries
module move_scheduler #(
  parameter int unsigned Depth = 4,
  parameter int unsigned StepW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       key_i,
  output logic             mv_en_o,
  output logic [1:0]       mv_dir_o,
  input  logic             moved_i,
  output logic             spawn_en_o,
  output logic             chk_en_o,
  input  logic             chk_done_i,
  input  logic             chk_dead_i,
  input  logic             chk_win_i,
  output logic [1:0]       status_o,
  output logic [StepW-1:0] step_o,
  output logic             busy_o,
  output logic             fifo_full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [1:0] StatPlay = 2'd0;
  localparam logic [1:0] StatDead = 2'd1;
  localparam logic [1:0] StatWin  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StSample,
    StSpawn,
    StCheck,
    StOver
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       key_q;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       status_q, status_d;
  logic [StepW-1:0] step_q, step_d;

  logic [1:0]       mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic             cmd_valid;
  logic [1:0]       cmd_dir;
  logic             fifo_empty, fifo_full;
  logic             push, pop, enter_over;

  // A command is a fresh press: exactly one key now, no key on the previous edge.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_dir   = 2'b00;
    if (key_q == 4'b0000) begin
      case (key_i)
        4'b1000: begin cmd_valid = 1'b1; cmd_dir = 2'b00; end
        4'b0100: begin cmd_valid = 1'b1; cmd_dir = 2'b01; end
        4'b0010: begin cmd_valid = 1'b1; cmd_dir = 2'b10; end
        4'b0001: begin cmd_valid = 1'b1; cmd_dir = 2'b11; end
        default: begin cmd_valid = 1'b0; cmd_dir = 2'b00; end
      endcase
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(Depth));
  assign pop        = (state_q == StIdle) && (status_q != StatDead) && !fifo_empty;
  assign enter_over = (state_q == StCheck) && chk_done_i && chk_dead_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = cmd_valid && (state_q != StOver) && !enter_over && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q <= 4'b1111;
    end else begin
      key_q <= key_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (enter_over) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_dir;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    status_d = status_q;
    step_d   = step_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          dir_d   = mem_q[rd_ptr_q];
          state_d = StMove;
        end
      end
      StMove:   state_d = StSample;
      StSample: state_d = moved_i ? StSpawn : StIdle;
      StSpawn:  state_d = StCheck;
      StCheck: begin
        if (chk_done_i) begin
          if (step_q != '1) step_d = step_q + StepW'(1);
          if (chk_dead_i) begin
            status_d = StatDead;
            state_d  = StOver;
          end else begin
            if (chk_win_i) status_d = StatWin;
            state_d = StIdle;
          end
        end
      end
      StOver:   state_d = StOver;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      dir_q    <= 2'b00;
      status_q <= StatPlay;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      status_q <= status_d;
      step_q   <= step_d;
    end
  end

  always_comb begin
    mv_en_o     = (state_q == StMove);
    spawn_en_o  = (state_q == StSpawn);
    chk_en_o    = (state_q == StCheck);
    busy_o      = (state_q != StIdle);
    mv_dir_o    = dir_q;
    status_o    = status_q;
    step_o      = step_q;
    fifo_full_o = fifo_full;
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: a turn-level model (command queue plus
// cycles-into-turn counter) is compared against the DUT every cycle, and
// hand-computed literals pin the totals after each scenario.
module tb_move_scheduler;

  localparam int unsigned Depth   = 4;
  localparam int unsigned StepW   = 8;
  localparam int          StepMax = (1 << StepW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       key;
  logic             mv_en;
  logic [1:0]       mv_dir;
  logic             moved;
  logic             spawn_en;
  logic             chk_en;
  logic             chk_done;
  logic             chk_dead;
  logic             chk_win;
  logic [1:0]       status;
  logic [StepW-1:0] step;
  logic             busy;
  logic             fifo_full;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  move_scheduler #(
    .Depth (Depth),
    .StepW (StepW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_i       (key),
    .mv_en_o     (mv_en),
    .mv_dir_o    (mv_dir),
    .moved_i     (moved),
    .spawn_en_o  (spawn_en),
    .chk_en_o    (chk_en),
    .chk_done_i  (chk_done),
    .chk_dead_i  (chk_dead),
    .chk_win_i   (chk_win),
    .status_o    (status),
    .step_o      (step),
    .busy_o      (busy),
    .fifo_full_o (fifo_full)
  );

  task automatic cmp(input string name, input logic [31:0] got, input int exp);
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input int exp);
    vectors++;
    cmp(name, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] mq[$];
  logic [3:0] m_pk;
  bit         m_turn, m_over, started;
  int         m_ph;       // cycles since the move strobe of the current turn
  logic [1:0] m_dir;
  int         m_status, m_step;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pk     = 4'hf;
      m_turn   = 0;
      m_over   = 0;
      m_ph     = 0;
      m_dir    = 2'b00;
      m_status = 0;
      m_step   = 0;
      started  = 1;
    end else if (started) begin
      bit         cmd;
      logic [1:0] d;
      cmd = ($countones(key) == 1) && (m_pk == 4'b0000);
      d   = key[3] ? 2'd0 : key[2] ? 2'd1 : key[1] ? 2'd2 : 2'd3;
      if (m_turn) begin
        if (m_ph == 1 && !moved) begin
          m_turn = 0;
        end else if (m_ph >= 3 && chk_done) begin
          if (m_step < StepMax) m_step++;
          m_turn = 0;
          if (chk_dead) begin
            m_status = 1;
            m_over   = 1;
            mq.delete();
          end else if (chk_win) begin
            m_status = 2;
          end
        end else begin
          m_ph++;
        end
      end else if (!m_over && mq.size() > 0) begin
        m_dir  = mq.pop_front();
        m_turn = 1;
        m_ph   = 0;
      end
      if (cmd && !m_over && mq.size() < Depth) mq.push_back(d);
      m_pk = key;
    end
  end

  // ---------------- per-cycle compare ----------------
  int         mv_cnt = 0, spawn_cnt = 0, chk_cyc = 0;
  logic [1:0] got_dirs[$];

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      cmp("mv_en",     mv_en,     int'(m_turn && m_ph == 0));
      cmp("spawn_en",  spawn_en,  int'(m_turn && m_ph == 2));
      cmp("chk_en",    chk_en,    int'(m_turn && m_ph >= 3));
      cmp("busy",      busy,      int'(m_turn || m_over));
      cmp("fifo_full", fifo_full, int'(mq.size() == Depth));
      cmp("mv_dir",    mv_dir,    int'(m_dir));
      cmp("status",    status,    m_status);
      cmp("step",      step,      m_step);
      if (mv_en === 1'b1) begin
        mv_cnt++;
        got_dirs.push_back(mv_dir);
      end
      if (spawn_en === 1'b1) spawn_cnt++;
      if (chk_en === 1'b1) chk_cyc++;
    end
  end

  // ---------------- check responder ----------------
  int chk_delay = 1;
  bit chk_hold  = 0;
  int chk_cnt   = 0;

  always @(negedge clk) begin
    if (chk_en === 1'b1 && !chk_hold) begin
      chk_done = (chk_cnt + 1 >= chk_delay);
      chk_cnt++;
    end else begin
      chk_done = 1'b0;
      if (chk_en !== 1'b1) chk_cnt = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key = k;
    @(negedge clk);
    key = 4'b0000;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    key      = 4'b1000;
    moved    = 1'b0;
    chk_dead = 1'b0;
    chk_win  = 1'b0;

    // 1: key held through reset must not fire
    cycles(3);
    settle();
    lit("rst_status", status, 0);
    lit("rst_step", step, 0);
    lit("rst_busy", busy, 0);
    lit("rst_full", fifo_full, 0);
    lit("rst_dir", mv_dir, 0);
    rst = 1'b0;
    cycles(10);
    settle();
    lit("held_no_move", mv_cnt, 0);
    lit("held_busy", busy, 0);
    key = 4'b0000;
    cycles(1);
    press(4'b0010);
    cycles(8);
    settle();
    lit("t1_moves", mv_cnt, 1);
    lit("t1_dir", mv_dir, 2);
    lit("t1_step", step, 0);

    // 2: effective move, check done on the third chk_en cycle
    moved     = 1'b1;
    chk_delay = 3;
    press(4'b1000);
    cycles(12);
    settle();
    lit("t2_moves", mv_cnt, 2);
    lit("t2_dir", mv_dir, 0);
    lit("t2_spawns", spawn_cnt, 1);
    lit("t2_chk_cycles", chk_cyc, 3);
    lit("t2_step", step, 1);
    lit("t2_busy", busy, 0);

    // 3: ineffective move, then a multi-hot pattern
    moved = 1'b0;
    press(4'b0001);
    cycles(8);
    settle();
    lit("t3_moves", mv_cnt, 3);
    lit("t3_dir", mv_dir, 3);
    lit("t3_spawns", spawn_cnt, 1);
    lit("t3_chk_cycles", chk_cyc, 3);
    lit("t3_step", step, 1);
    key = 4'b1100;
    cycles(3);
    key = 4'b0000;
    cycles(6);
    settle();
    lit("t3_multihot", mv_cnt, 3);

    // 4: overflow while a check is stalled
    moved     = 1'b1;
    chk_delay = 1;
    chk_hold  = 1;
    press(4'b1000);
    cycles(6);
    settle();
    lit("t4_stalled", chk_en, 1);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] k;
      k = 4'b1000 >> (i % 4);
      press(k);
    end
    settle();
    lit("t4_full", fifo_full, 1);
    chk_hold = 0;
    cycles(60);
    settle();
    lit("t4_moves", mv_cnt, 8);
    for (int i = 0; i < 4; i++) begin
      lit("t4_order", got_dirs[got_dirs.size() - 4 + i], i);
    end
    lit("t4_step", step, 6);
    lit("t4_not_full", fifo_full, 0);

    // 5: win keeps playing, dead (with win) ends the game
    chk_win = 1'b1;
    press(4'b0010);
    cycles(10);
    settle();
    lit("t5_win", status, 2);
    lit("t5_step", step, 7);
    chk_dead = 1'b1;
    press(4'b0100);
    cycles(10);
    settle();
    lit("t5_dead", status, 1);
    lit("t5_dead_step", step, 8);
    lit("t5_over_busy", busy, 1);
    chk_dead = 1'b0;
    chk_win  = 1'b0;
    press(4'b1000);
    press(4'b0001);
    cycles(8);
    settle();
    lit("t5_over_moves", mv_cnt, 10);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    settle();
    lit("t5_rst_status", status, 0);
    lit("t5_rst_step", step, 0);
    lit("t5_rst_busy", busy, 0);

    // 6: step saturation
    key = 4'b0000;
    cycles(2);
    base = mv_cnt;
    for (int i = 0; i < 255; i++) begin
      press(4'b1000 >> (i % 4));
      cycles(6);
    end
    settle();
    lit("t6_step255", step, 255);
    press(4'b0001);
    cycles(8);
    settle();
    lit("t6_saturate", step, 255);
    lit("t6_moves", mv_cnt - base, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
